uart_reg_bridge: RTL

// - Register-bus initiator driven by a UART byte stream; the master counterpart of the uart_core register port.
// - Parses command frames from a received byte stream, issues reg_we/reg_re accesses, and returns ACK/NAK or read data as a byte stream.
// - Sits between a uart_rx/uart_tx pair (byte level) and a peripheral's reg_* port, as a host debug/config path.

---
 rtl/uart_bridge_pkg.sv | 36 +++
 rtl/uart_bridge_timeout.sv | 44 ++++
 rtl/uart_reg_bridge.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - shared constants, state type and helpers for the UART register bridge
//
// Purpose: command/response byte codes, the bridge FSM state enum and the
// response byte selector used by uart_reg_bridge.
// Ports: none (package).

package uart_bridge_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR_HI = 3'd1,
        S_ADDR_LO = 3'd2,
        S_DATA    = 3'd3,
        S_EXEC    = 3'd4,
        S_WAIT_RD = 3'd5,
        S_RESP    = 3'd6
    } bridge_state_e;

    // Response bytes go out MSB first: index 0 is word[31:24].
    function automatic logic [7:0] resp_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_bridge_timeout.sv
// rtl/uart_bridge_timeout.sv - saturating inter-byte gap counter
//
// Purpose: counts cycles between received bytes of one frame and flags when
// the gap reaches LIMIT. The count holds at LIMIT instead of wrapping.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   clr_i          load zero (has priority over en_i)
//   en_i           count this cycle
//   expired_o      count has reached LIMIT

module uart_bridge_timeout #(
    parameter int unsigned LIMIT = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == CW'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_reg_bridge.sv
// rtl/uart_reg_bridge.sv - UART byte stream to register bus initiator
//
// Purpose: parses CMD/ADDR_HI/ADDR_LO[/DATA x4] frames from a received byte
// stream, issues one reg_we or reg_re strobe per frame and returns ACK, NAK
// or four read-data bytes on a valid/ready byte stream.
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   rx_byte_i, rx_valid_i            received byte strobe (no backpressure)
//   tx_byte_o, tx_valid_o, tx_ready_i response byte stream
//   reg_addr, reg_wdata, reg_we,
//   reg_re, reg_rdata                register bus initiator port
//   busy_o                           frame in progress (state != IDLE)
//   err_o, err_clr_i                 sticky error flag and its clear

module uart_reg_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned READ_LATENCY   = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_byte_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_byte_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [11:0] reg_addr,
    output logic [31:0] reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [31:0] reg_rdata,
    output logic        busy_o,
    output logic        err_o,
    input  logic        err_clr_i
);

    bridge_state_e state_q;

    logic        is_wr_q;
    logic [11:0] addr_sh_q;
    logic [23:0] wdata_sh_q;
    logic [1:0]  byte_cnt_q;
    logic [1:0]  resp_last_q;
    logic [2:0]  lat_q;
    logic [31:0] resp_q;

    logic [7:0]  tx_byte_q;
    logic        tx_valid_q;
    logic [11:0] reg_addr_q;
    logic [31:0] reg_wdata_q;
    logic        reg_we_q;
    logic        reg_re_q;
    logic        err_q;

    logic in_frame;
    logic tmo_expired;
    logic cmd_ok;
    logic bad_cmd;
    logic tmo_hit;
    logic overrun;

    assign in_frame = (state_q == S_ADDR_HI) || (state_q == S_ADDR_LO) || (state_q == S_DATA);
    assign cmd_ok   = (rx_byte_i == CMD_WR) || (rx_byte_i == CMD_RD);
    assign bad_cmd  = (state_q == S_IDLE) && rx_valid_i && !cmd_ok;
    // A byte arriving in the expiry cycle still counts; only a silent cycle times out.
    assign tmo_hit  = in_frame && !rx_valid_i && tmo_expired;
    assign overrun  = rx_valid_i &&
                      ((state_q == S_EXEC) || (state_q == S_WAIT_RD) || (state_q == S_RESP));

    uart_bridge_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (rx_valid_i || !in_frame),
        .en_i      (in_frame),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            is_wr_q     <= 1'b0;
            addr_sh_q   <= '0;
            wdata_sh_q  <= '0;
            byte_cnt_q  <= '0;
            resp_last_q <= '0;
            lat_q       <= '0;
            resp_q      <= '0;
            tx_byte_q   <= '0;
            tx_valid_q  <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // Strobes are high for the single EXEC cycle only.
            reg_we_q <= 1'b0;
            reg_re_q <= 1'b0;

            if (bad_cmd || tmo_hit || overrun) begin
                err_q <= 1'b1;
            end else if (err_clr_i) begin
                err_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (rx_valid_i) begin
                        if (cmd_ok) begin
                            is_wr_q <= (rx_byte_i == CMD_WR);
                            state_q <= S_ADDR_HI;
                        end else begin
                            resp_q      <= {RSP_NAK, 24'h0};
                            resp_last_q <= 2'd0;
                            byte_cnt_q  <= 2'd0;
                            state_q     <= S_RESP;
                        end
                    end
                end
                S_ADDR_HI: begin
                    if (rx_valid_i) begin
                        addr_sh_q[11:8] <= rx_byte_i[3:0];
                        state_q         <= S_ADDR_LO;
                    end else if (tmo_expired) begin
                        state_q <= S_IDLE;
                    end
                end
                S_ADDR_LO: begin
                    if (rx_valid_i) begin
                        addr_sh_q[7:0] <= rx_byte_i;
                        byte_cnt_q     <= 2'd0;
                        if (is_wr_q) begin
                            state_q <= S_DATA;
                        end else begin
                            reg_addr_q <= {addr_sh_q[11:8], rx_byte_i};
                            reg_re_q   <= 1'b1;
                            state_q    <= S_EXEC;
                        end
                    end else if (tmo_expired) begin
                        state_q <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (rx_valid_i) begin
                        wdata_sh_q <= {wdata_sh_q[15:0], rx_byte_i};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            reg_addr_q  <= addr_sh_q;
                            reg_wdata_q <= {wdata_sh_q, rx_byte_i};
                            reg_we_q    <= 1'b1;
                            state_q     <= S_EXEC;
                        end
                    end else if (tmo_expired) begin
                        state_q <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    if (is_wr_q) begin
                        resp_q      <= {RSP_ACK, 24'h0};
                        resp_last_q <= 2'd0;
                        byte_cnt_q  <= 2'd0;
                        state_q     <= S_RESP;
                    end else begin
                        lat_q   <= 3'd1;
                        state_q <= S_WAIT_RD;
                    end
                end
                S_WAIT_RD: begin
                    // lat_q counts cycles since the reg_re cycle.
                    if (lat_q == 3'(READ_LATENCY)) begin
                        resp_q      <= reg_rdata;
                        resp_last_q <= 2'd3;
                        byte_cnt_q  <= 2'd0;
                        state_q     <= S_RESP;
                    end else begin
                        lat_q <= lat_q + 3'd1;
                    end
                end
                S_RESP: begin
                    if (!tx_valid_q) begin
                        tx_valid_q <= 1'b1;
                        tx_byte_q  <= resp_byte(resp_q, byte_cnt_q);
                    end else if (tx_ready_i) begin
                        if (byte_cnt_q == resp_last_q) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            tx_byte_q  <= resp_byte(resp_q, byte_cnt_q + 2'd1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_byte_o  = tx_byte_q;
    assign tx_valid_o = tx_valid_q;
    assign reg_addr   = reg_addr_q;
    assign reg_wdata  = reg_wdata_q;
    assign reg_we     = reg_we_q;
    assign reg_re     = reg_re_q;
    assign busy_o     = (state_q != S_IDLE);
    assign err_o      = err_q;

endmodule
